// File: rtl/axis_bank_writer_pkg.sv
// axis_bank_writer_pkg: shared state encoding and width helpers for the banked stream writer
package axis_bank_writer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CONFIG = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
  function automatic int half_addr_w(input int aw);
    return aw - 1;
  endfunction
  function automatic int bank_idx_w(input int bn);
    return $clog2(bn);
  endfunction
endpackage

// File: rtl/axis_bank_writer_bank_addr_gen.sv
// bank_addr_gen: beat/bank/base counters producing the next in-half address and bank one-hot
module bank_addr_gen
  import axis_bank_writer_pkg::*;
#(
  parameter int BANK_NUM = 6,
  parameter int ADDR_WIDTH = 9,
  parameter int ROW_W = 8,
  localparam int HW = half_addr_w(ADDR_WIDTH),
  localparam int BW = bank_idx_w(BANK_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                step,
  input  logic                last,
  input  logic [ROW_W-1:0]    row_deep,
  input  logic [HW-1:0]       stride,
  output logic [HW-1:0]       addr,
  output logic [BANK_NUM-1:0] bank_oh,
  output logic                row_end
);
  logic [ROW_W-1:0] beat;
  logic [BW-1:0] bank;
  logic [HW-1:0] base;
  logic bank_end;
  assign row_end = beat == row_deep - 1'b1;
  assign bank_end = bank == BW'(BANK_NUM - 1);
  assign addr = base + HW'(beat);
  assign bank_oh = BANK_NUM'(1) << bank;
  always_ff @(posedge clk)
    if (rst || clear || (step && last)) begin
      beat <= '0;
      bank <= '0;
      base <= '0;
    end else if (step && row_end) begin
      beat <= '0;
      bank <= bank_end ? '0 : bank + 1'b1;
      base <= bank_end ? base + stride : base;
    end else if (step) begin
      beat <= beat + 1'b1;
    end
endmodule

// File: rtl/axis_bank_writer.sv
// axis_bank_writer: AXI-Stream to banked BRAM writer with ping/pong halves, release handshake and job sequencing
module axis_bank_writer
  import axis_bank_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BANK_NUM = 6,
  parameter int ADDR_WIDTH = 9,
  parameter int ROW_W = 8,
  parameter int TILE_W = 10,
  parameter int BLOCK_W = 6,
  parameter int LOOP_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-2:0] cfg_stride,
  input  logic [ROW_W-1:0]      row_deep,
  input  logic [TILE_W-1:0]     tile_deep,
  input  logic [BLOCK_W-1:0]    block_deep,
  input  logic [LOOP_W-1:0]     loop_deep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [1:0]            buf_release,
  output logic [1:0]            buf_full,
  output logic [BANK_NUM-1:0]   en_wr,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic                  slice_done,
  output logic                  len_err,
  output logic                  done,
  output logic                  busy
);
  localparam int HW = half_addr_w(ADDR_WIDTH);
  state_t state, state_n;
  logic wr_half, hs, tl, row_end, tile_end, block_end, loop_end;
  logic [ROW_W-1:0] rd_q;
  logic [TILE_W-1:0] td_q, tile;
  logic [BLOCK_W-1:0] bd_q, block;
  logic [LOOP_W-1:0] ld_q, loop_cnt;
  logic [HW-1:0] stride_q, addr_nx;
  logic [BANK_NUM-1:0] bank_oh;
  assign s_axis_tready = state == RUN && !buf_full[wr_half];
  assign hs = s_axis_tvalid && s_axis_tready;
  assign tl = hs && s_axis_tlast;
  assign tile_end = tile == td_q - 1'b1;
  assign block_end = block == bd_q - 1'b1;
  assign loop_end = loop_cnt == ld_q - 1'b1;
  assign busy = state != IDLE;
  bank_addr_gen #(.BANK_NUM(BANK_NUM), .ADDR_WIDTH(ADDR_WIDTH), .ROW_W(ROW_W)) u_gen (
    .clk(clk),
    .rst(rst),
    .clear(state == CONFIG),
    .step(hs),
    .last(s_axis_tlast),
    .row_deep(rd_q),
    .stride(stride_q),
    .addr(addr_nx),
    .bank_oh(bank_oh),
    .row_end(row_end)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? CONFIG : IDLE;
      CONFIG:  state_n = RUN;
      RUN:     state_n = tl && tile_end && block_end && loop_end ? DONE : RUN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk)
    if (rst) begin
      wr_half <= 1'b0;
      buf_full <= '0;
      en_wr <= '0;
      addr_wr <= '0;
      data_wr <= '0;
      slice_done <= 1'b0;
      len_err <= 1'b0;
      done <= 1'b0;
      rd_q <= '0;
      td_q <= '0;
      bd_q <= '0;
      ld_q <= '0;
      stride_q <= '0;
      tile <= '0;
      block <= '0;
      loop_cnt <= '0;
    end else begin
      en_wr <= hs ? bank_oh : '0;
      if (hs) begin
        addr_wr <= {wr_half, addr_nx};
        data_wr <= s_axis_tdata;
      end
      slice_done <= tl;
      len_err <= tl && !row_end;
      done <= state == DONE;
      buf_full <= (buf_full | {tl && wr_half, tl && !wr_half}) & ~buf_release;
      if (state == CONFIG) begin
        rd_q <= row_deep == '0 ? ROW_W'(1) : row_deep;
        td_q <= tile_deep == '0 ? TILE_W'(1) : tile_deep;
        bd_q <= block_deep == '0 ? BLOCK_W'(1) : block_deep;
        ld_q <= loop_deep == '0 ? LOOP_W'(1) : loop_deep;
        stride_q <= cfg_stride;
        tile <= '0;
        block <= '0;
        loop_cnt <= '0;
        wr_half <= 1'b0;
      end else if (tl) begin
        wr_half <= ~wr_half;
        tile <= tile_end ? '0 : tile + 1'b1;
        if (tile_end) block <= block_end ? '0 : block + 1'b1;
        if (tile_end && block_end) loop_cnt <= loop_end ? '0 : loop_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_axis_bank_writer.sv
// tb_axis_bank_writer: directed scoreboard bench for axis_bank_writer
module tb_axis_bank_writer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] cfg_stride = '0, row_deep = '0;
  logic [9:0] tile_deep = '0;
  logic [5:0] block_deep = '0;
  logic [4:0] loop_deep = '0;
  logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [1:0] buf_release = '0, buf_full;
  logic [5:0] en_wr;
  logic [8:0] addr_wr;
  logic [63:0] data_wr;
  logic slice_done, len_err, done, busy;
  int checks = 0, errors = 0;
  int cur_half, cur_n, cur_rd, cur_stride;
  logic [78:0] q[$];

  axis_bank_writer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_stride(cfg_stride), .row_deep(row_deep),
    .tile_deep(tile_deep), .block_deep(block_deep), .loop_deep(loop_deep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .buf_release(buf_release), .buf_full(buf_full),
    .en_wr(en_wr), .addr_wr(addr_wr), .data_wr(data_wr), .slice_done(slice_done),
    .len_err(len_err), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] exp_wr(input int half, input int n, input int rd, input int stride);
    int r, a;
    logic [5:0] en;
    r = n / rd;
    a = ((r / 6) * stride + n % rd) % 256;
    en = 6'(1) << (r % 6);
    return {en, 9'(half * 256 + a)};
  endfunction

  always @(negedge clk)
    if (en_wr !== '0) begin
      if (q.size() == 0) chk("unexpected_write", 79'(en_wr), 79'(0));
      else chk("write", {en_wr, addr_wr, data_wr}, q.pop_front());
    end

  task automatic start_job(input int rd, input int td, input int bd, input int ld, input int stride);
    row_deep = 8'(rd);
    tile_deep = 10'(td);
    block_deep = 6'(bd);
    loop_deep = 5'(ld);
    cfg_stride = 8'(stride);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cur_half = 0;
    cur_n = 0;
    cur_rd = rd == 0 ? 1 : rd;
    cur_stride = stride;
  endtask

  task automatic send_beat(input bit last);
    logic [63:0] d;
    int w;
    d = {$urandom, $urandom};
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    s_axis_tlast = last;
    w = 0;
    while (!s_axis_tready && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("tready_wait", 79'(s_axis_tready), 79'(1));
    if (s_axis_tready) begin
      q.push_back({exp_wr(cur_half, cur_n, cur_rd, cur_stride), d});
      @(posedge clk);
      cur_n = last ? 0 : cur_n + 1;
      if (last) cur_half ^= 1;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic send_slice(input int n);
    for (int i = 0; i < n; i++) send_beat(i == n - 1);
  endtask

  task automatic pulse_release(input logic [1:0] b);
    buf_release = b;
    @(negedge clk);
    buf_release = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {en_wr, addr_wr, data_wr}, 79'(0));
    chk("reset_flags", 79'({slice_done, len_err, done, busy, buf_full, s_axis_tready}), 79'(0));
    rst = 1'b0;
    @(negedge clk);
    // row/bank distribution, zero depths treated as one
    start_job(4, 1, 0, 0, 128);
    chk("t1_busy", 79'(busy), 79'(1));
    chk("t1_tready", 79'(s_axis_tready), 79'(1));
    send_slice(28);
    chk("t1_slice_done", 79'(slice_done), 79'(1));
    chk("t1_buf_full", 79'(buf_full), 79'(2'b01));
    chk("t1_done_early", 79'(done), 79'(0));
    @(negedge clk);
    chk("t1_slice_done_low", 79'(slice_done), 79'(0));
    chk("t1_done", 79'(done), 79'(1));
    chk("t1_busy_low", 79'(busy), 79'(0));
    pulse_release(2'b01);
    chk("t1_released", 79'(buf_full), 79'(0));
    // ping/pong with backpressure
    start_job(4, 3, 1, 1, 128);
    send_slice(4);
    send_slice(4);
    chk("t2_full_both", 79'(buf_full), 79'(2'b11));
    s_axis_tvalid = 1'b1;
    repeat (4) begin
      chk("t2_blocked", 79'(s_axis_tready), 79'(0));
      @(negedge clk);
    end
    chk("t2_no_write", 79'(q.size()), 79'(0));
    buf_release = 2'b01;
    @(negedge clk);
    buf_release = 2'b00;
    chk("t2_after_release", 79'(buf_full), 79'(2'b10));
    chk("t2_tready", 79'(s_axis_tready), 79'(1));
    send_slice(4);
    chk("t2_full_end", 79'(buf_full), 79'(2'b11));
    @(negedge clk);
    chk("t2_done", 79'(done), 79'(1));
    pulse_release(2'b11);
    // length error
    start_job(4, 2, 1, 1, 128);
    send_slice(3);
    chk("t3_len_err", 79'(len_err), 79'(1));
    chk("t3_buf_full", 79'(buf_full), 79'(2'b01));
    send_beat(0);
    chk("t3_len_err_low", 79'(len_err), 79'(0));
    send_slice(3);
    chk("t3_good_len", 79'(len_err), 79'(0));
    @(negedge clk);
    chk("t3_done", 79'(done), 79'(1));
    pulse_release(2'b11);
    // job completion over nested counters
    start_job(2, 2, 2, 2, 5);
    for (int s = 0; s < 8; s++) begin
      if (s == 2) begin
        send_beat(0);
        start = 1'b1;
        send_beat(1);
        start = 1'b0;
      end else send_slice(2);
      chk("t4_slice_done", 79'(slice_done), 79'(1));
      chk("t4_done_low", 79'(done), 79'(0));
      chk("t4_busy", 79'(busy), 79'(1));
      if (s < 7) pulse_release(s % 2 == 0 ? 2'b01 : 2'b10);
    end
    @(negedge clk);
    chk("t4_done", 79'(done), 79'(1));
    chk("t4_busy_low", 79'(busy), 79'(0));
    @(negedge clk);
    chk("t4_done_once", 79'(done), 79'(0));
    pulse_release(2'b10);
    // address wrap within the half
    start_job(200, 1, 1, 1, 128);
    send_slice(1400);
    @(negedge clk);
    chk("t5_done", 79'(done), 79'(1));
    pulse_release(2'b01);
    // reset mid-slice
    start_job(4, 1, 1, 1, 128);
    repeat (10) send_beat(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_outputs", {en_wr, addr_wr, data_wr}, 79'(0));
    chk("t6_flags", 79'({slice_done, len_err, done, busy, buf_full, s_axis_tready}), 79'(0));
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_done", 79'({done, busy}), 79'(0));
    end
    start_job(4, 1, 1, 1, 128);
    send_slice(4);
    @(negedge clk);
    chk("t6_restart_done", 79'(done), 79'(1));
    pulse_release(2'b01);
    @(negedge clk);
    chk("scoreboard_empty", 79'(q.size()), 79'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
